// File: rtl/agc_mon_pkg.sv
// Shared types and constants for the monitor time-pulse decoder:
// tracker states, pattern classes, TCODE limits and ERRCODE field layout.
package agc_mon_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    TRACK     = 2'd1,
    STALLED   = 2'd2
  } mon_state_t;

  typedef enum logic [1:0] {
    PAT_ZERO   = 2'd0,
    PAT_ONEHOT = 2'd1,
    PAT_MULTI  = 2'd2
  } pat_class_t;

  localparam int unsigned TCODE_W = 4;
  localparam int unsigned ERR_W   = 8;

  localparam logic [TCODE_W-1:0] T_NONE  = 4'd0;
  localparam logic [TCODE_W-1:0] T_FIRST = 4'd1;
  localparam logic [TCODE_W-1:0] T_LAST  = 4'd12;

  // ERRCODE = {expected, got}
  localparam int ERR_EXP_MSB = 7;
  localparam int ERR_EXP_LSB = 4;
  localparam int ERR_GOT_MSB = 3;
  localparam int ERR_GOT_LSB = 0;

  function automatic pat_class_t classify(input logic [11:0] p);
    pat_class_t c;
    case ($countones(p))
      0:       c = PAT_ZERO;
      1:       c = PAT_ONEHOT;
      default: c = PAT_MULTI;
    endcase
    return c;
  endfunction

  // Only meaningful for one-hot input; bit 0 is MT01.
  function automatic logic [TCODE_W-1:0] encode(input logic [11:0] p);
    logic [TCODE_W-1:0] c;
    c = T_NONE;
    for (int i = 0; i < 12; i++) begin
      if (p[i]) c = 4'(i + 1);
    end
    return c;
  endfunction

  function automatic logic [TCODE_W-1:0] next_tcode(input logic [TCODE_W-1:0] t);
    return (t == T_LAST) ? T_FIRST : t + 4'd1;
  endfunction

endpackage

// File: rtl/mon_timepulse_decoder_if.sv
// Bundle of the monitor time-pulse lines, control strobes and decoder results.
// master drives the timer-side lines; slave is the decoder.
interface mon_timepulse_decoder_if;
  import agc_mon_pkg::*;

  logic MT01, MT02, MT03, MT04, MT05, MT06;
  logic MT07, MT08, MT09, MT10, MT11, MT12;
  logic GOJAM;
  logic ERR_CLR;

  logic [TCODE_W-1:0] TCODE;
  logic               TVALID;
  logic               TSTEP;
  logic [15:0]        MCT_CNT;
  logic               SEQERR;
  logic               MULTI;
  logic [ERR_W-1:0]   ERRCODE;
  logic               STALL;

  modport master (
    output MT01, MT02, MT03, MT04, MT05, MT06,
    output MT07, MT08, MT09, MT10, MT11, MT12,
    output GOJAM, ERR_CLR,
    input  TCODE, TVALID, TSTEP, MCT_CNT, SEQERR, MULTI, ERRCODE, STALL
  );

  modport slave (
    input  MT01, MT02, MT03, MT04, MT05, MT06,
    input  MT07, MT08, MT09, MT10, MT11, MT12,
    input  GOJAM, ERR_CLR,
    output TCODE, TVALID, TSTEP, MCT_CNT, SEQERR, MULTI, ERRCODE, STALL
  );

endinterface

// File: rtl/mon_timepulse_decoder_settle.sv
// Input register plus stability counter: a sample pattern that stays unchanged
// for SETTLE consecutive samples produces exactly one accept strobe.
module mon_settle_filter
  import agc_mon_pkg::*;
#(
  parameter int unsigned SETTLE = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [11:0]        i_mt,
  output logic               o_accept,
  output pat_class_t         o_class,
  output logic [TCODE_W-1:0] o_code
);

  localparam int unsigned CW = $clog2(SETTLE + 1);

  logic [11:0]        r_sample;
  logic [CW-1:0]      r_cnt;
  logic               r_accept;
  pat_class_t         r_class;
  logic [TCODE_W-1:0] r_code;

  logic               w_changed;
  logic [CW-1:0]      w_cnt_next;
  logic               w_accept_next;

  // Counter saturates at SETTLE so a held pattern fires only on the edge it gets there.
  always_comb begin
    w_changed = (i_mt != r_sample);
    if (w_changed)
      w_cnt_next = CW'(1);
    else if (r_cnt == CW'(SETTLE))
      w_cnt_next = r_cnt;
    else
      w_cnt_next = r_cnt + CW'(1);
    w_accept_next = (w_cnt_next == CW'(SETTLE)) && (w_changed || (r_cnt != CW'(SETTLE)));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample <= '0;
      r_cnt    <= '0;
      r_accept <= 1'b0;
      r_class  <= PAT_ZERO;
      r_code   <= T_NONE;
    end else begin
      r_sample <= i_mt;
      r_cnt    <= w_cnt_next;
      r_accept <= w_accept_next;
      r_class  <= classify(i_mt);
      r_code   <= encode(i_mt);
    end
  end

  assign o_accept = r_accept;
  assign o_class  = r_class;
  assign o_code   = r_code;

endmodule

// File: rtl/mon_timepulse_decoder.sv
// Monitor-side decoder for the MT01..MT12 time pulses: tracks the pulse
// sequence, counts memory cycles and raises sequence/multi-hot/stall flags.
module mon_timepulse_decoder
  import agc_mon_pkg::*;
#(
  parameter int unsigned SETTLE      = 3,
  parameter int unsigned STALL_LIMIT = 128
) (
  input  logic                     SIM_CLK,
  input  logic                     RESET,
  mon_timepulse_decoder_if.slave   mon
);

  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  logic [11:0]        w_mt;
  logic               w_accept;
  pat_class_t         w_class;
  logic [TCODE_W-1:0] w_code;
  logic [TCODE_W-1:0] w_expected;
  logic               w_seqerr_held;

  mon_state_t         r_state;
  logic [TCODE_W-1:0] r_tcode;
  logic               r_tvalid;
  logic               r_tstep;
  logic [15:0]        r_mct_cnt;
  logic               r_seqerr;
  logic               r_multi;
  logic [ERR_W-1:0]   r_errcode;
  logic [SW-1:0]      r_stall_cnt;

  assign w_mt = {mon.MT12, mon.MT11, mon.MT10, mon.MT09, mon.MT08, mon.MT07,
                 mon.MT06, mon.MT05, mon.MT04, mon.MT03, mon.MT02, mon.MT01};

  mon_settle_filter #(
    .SETTLE (SETTLE)
  ) u_filter (
    .i_clk    (SIM_CLK),
    .i_rst    (RESET),
    .i_mt     (w_mt),
    .o_accept (w_accept),
    .o_class  (w_class),
    .o_code   (w_code)
  );

  // A same-cycle ERR_CLR counts as "SEQERR clear" so a fresh error captures ERRCODE.
  always_comb begin
    w_expected    = next_tcode(r_tcode);
    w_seqerr_held = r_seqerr && !mon.ERR_CLR;
  end

  always_ff @(posedge SIM_CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= SYNC_WAIT;
      r_tcode     <= T_NONE;
      r_tvalid    <= 1'b0;
      r_tstep     <= 1'b0;
      r_mct_cnt   <= '0;
      r_seqerr    <= 1'b0;
      r_multi     <= 1'b0;
      r_errcode   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_tstep <= 1'b0;

      if (mon.ERR_CLR) begin
        r_seqerr  <= 1'b0;
        r_multi   <= 1'b0;
        r_errcode <= '0;
      end

      if (mon.GOJAM) begin
        r_state     <= SYNC_WAIT;
        r_tcode     <= T_NONE;
        r_tvalid    <= 1'b0;
        r_stall_cnt <= '0;
      end else begin
        if (r_stall_cnt != SW'(STALL_LIMIT))
          r_stall_cnt <= r_stall_cnt + SW'(1);
        if ((r_state == TRACK) && (r_stall_cnt >= SW'(STALL_LIMIT - 1)))
          r_state <= STALLED;

        // A one-hot acceptance below overrides the stall transition above.
        if (w_accept) begin
          case (w_class)
            PAT_MULTI: r_multi <= 1'b1;
            PAT_ONEHOT: begin
              if (r_state == TRACK) begin
                if (w_code == w_expected) begin
                  if (r_tcode == T_LAST)
                    r_mct_cnt <= r_mct_cnt + 16'd1;
                end else begin
                  if (!w_seqerr_held) begin
                    r_errcode[ERR_EXP_MSB:ERR_EXP_LSB] <= w_expected;
                    r_errcode[ERR_GOT_MSB:ERR_GOT_LSB] <= w_code;
                  end
                  r_seqerr <= 1'b1;
                end
              end
              r_tcode     <= w_code;
              r_tvalid    <= 1'b1;
              r_tstep     <= 1'b1;
              r_stall_cnt <= '0;
              r_state     <= TRACK;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign mon.TCODE   = r_tcode;
  assign mon.TVALID  = r_tvalid;
  assign mon.TSTEP   = r_tstep;
  assign mon.MCT_CNT = r_mct_cnt;
  assign mon.SEQERR  = r_seqerr;
  assign mon.MULTI   = r_multi;
  assign mon.ERRCODE = r_errcode;
  assign mon.STALL   = (r_state == STALLED);

endmodule

// File: tb/tb_mon_timepulse_decoder.sv
// Bench for mon_timepulse_decoder: directed scenarios plus random pulse trains,
// every cycle compared against an edge-indexed behavioural model.
module tb_mon_timepulse_decoder;
  import agc_mon_pkg::*;

  localparam int SETTLE      = 3;
  localparam int STALL_LIMIT = 128;

  logic SIM_CLK = 1'b0;
  logic RESET   = 1'b1;

  mon_timepulse_decoder_if bus ();

  mon_timepulse_decoder #(
    .SETTLE      (SETTLE),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .SIM_CLK (SIM_CLK),
    .RESET   (RESET),
    .mon     (bus)
  );

  always #10 SIM_CLK = ~SIM_CLK;

  int n_vec = 0;
  int n_err = 0;

  // Model: edge counter, start edge of the current sampled pattern, last step edge.
  int          e = 0;
  logic [11:0] m_pat;
  int          m_start, m_last;
  int          m_tcode, m_tvalid, m_tstep, m_mct, m_seqerr, m_multi, m_errcode;
  int          m_state;           // 0 sync-wait, 1 track, 2 stalled
  logic [11:0] cur_mt = '0;
  logic        cur_gj = 1'b0, cur_ec = 1'b0;
  logic        prev_tstep = 1'b0;
  int          n_dut_steps = 0;
  bit          rnd_mode = 0;
  int          last_code = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  function automatic logic [11:0] onehot(input int c);
    logic [11:0] one;
    one = 12'd1;
    return (c >= 1 && c <= 12) ? (one << (c - 1)) : 12'd0;
  endfunction

  task automatic model_reset();
    m_pat = '0; m_start = e + 1; m_last = e;
    m_tcode = 0; m_tvalid = 0; m_tstep = 0; m_mct = 0;
    m_seqerr = 0; m_multi = 0; m_errcode = 0; m_state = 0;
    prev_tstep = 1'b0;
  endtask

  task automatic model_edge();
    int n, code, expd;
    bit acc;
    e++;
    m_tstep = 0;
    acc = ((e - m_start) == SETTLE);
    if (cur_ec) begin m_seqerr = 0; m_multi = 0; m_errcode = 0; end
    if (cur_gj) begin
      m_state = 0; m_tcode = 0; m_tvalid = 0; m_last = e;
    end else begin
      if (m_state == 1 && (e - m_last) == STALL_LIMIT) m_state = 2;
      if (acc) begin
        n = $countones(m_pat);
        if (n > 1) m_multi = 1;
        else if (n == 1) begin
          code = 0;
          for (int i = 0; i < 12; i++) if (m_pat[i]) code = i + 1;
          if (m_state == 1) begin
            expd = (m_tcode % 12) + 1;
            if (code == expd) begin
              if (m_tcode == 12) m_mct = (m_mct + 1) & 16'hFFFF;
            end else begin
              if (m_seqerr == 0) m_errcode = expd * 16 + code;
              m_seqerr = 1;
            end
          end
          m_tcode = code; m_tvalid = 1; m_tstep = 1; m_last = e; m_state = 1;
        end
      end
    end
    if (cur_mt != m_pat) begin m_pat = cur_mt; m_start = e; end
  endtask

  task automatic compare_all();
    check_val("TCODE",   32'(bus.TCODE),   32'(m_tcode));
    check_val("TVALID",  32'(bus.TVALID),  32'(m_tvalid));
    check_val("TSTEP",   32'(bus.TSTEP),   32'(m_tstep));
    check_val("MCT_CNT", 32'(bus.MCT_CNT), 32'(m_mct));
    check_val("SEQERR",  32'(bus.SEQERR),  32'(m_seqerr));
    check_val("MULTI",   32'(bus.MULTI),   32'(m_multi));
    check_val("ERRCODE", 32'(bus.ERRCODE), 32'(m_errcode));
    check_val("STALL",   32'(bus.STALL),   32'(m_state == 2));
    check_val("TSTEP_GAP", 32'(bus.TSTEP & prev_tstep), 32'd0);
    if (bus.TSTEP) n_dut_steps++;
    prev_tstep = bus.TSTEP;
  endtask

  task automatic set_inputs(input logic [11:0] mt, input logic gj, input logic ec);
    cur_mt = mt; cur_gj = gj; cur_ec = ec;
    bus.MT01 = mt[0];  bus.MT02 = mt[1];  bus.MT03 = mt[2];  bus.MT04 = mt[3];
    bus.MT05 = mt[4];  bus.MT06 = mt[5];  bus.MT07 = mt[6];  bus.MT08 = mt[7];
    bus.MT09 = mt[8];  bus.MT10 = mt[9];  bus.MT11 = mt[10]; bus.MT12 = mt[11];
    bus.GOJAM = gj;    bus.ERR_CLR = ec;
  endtask

  task automatic step(input logic [11:0] mt, input logic gj, input logic ec);
    set_inputs(mt, gj, ec);
    @(posedge SIM_CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive_pat(input logic [11:0] mt, input int len);
    logic ec;
    for (int i = 0; i < len; i++) begin
      ec = rnd_mode && ($urandom_range(0, 39) == 0);
      step(mt, 1'b0, ec);
    end
    $display("pulse pat=%03h len=%0d -> TCODE=%0d TVALID=%0b MCT=%0d SEQERR=%0b MULTI=%0b ERRCODE=%02h STALL=%0b",
             mt, len, bus.TCODE, bus.TVALID, bus.MCT_CNT, bus.SEQERR, bus.MULTI, bus.ERRCODE, bus.STALL);
  endtask

  task automatic drive_code(input int c, input int len);
    drive_pat(onehot(c), len);
    last_code = c;
  endtask

  initial begin
    int lag, cnt, steps_before, saved_mct, kind, c, a, b, ov;

    set_inputs('0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge SIM_CLK);
    @(negedge SIM_CLK);
    RESET = 1'b0;
    model_reset();
    check_val("RST_TCODE",  32'(bus.TCODE),   32'd0);
    check_val("RST_TVALID", 32'(bus.TVALID),  32'd0);
    check_val("RST_MCT",    32'(bus.MCT_CNT), 32'd0);
    check_val("RST_STALL",  32'(bus.STALL),   32'd0);

    // Clean T01..T12 x3
    n_dut_steps = 0;
    for (int r = 0; r < 3; r++)
      for (int k = 1; k <= 12; k++) drive_code(k, 49);
    check_val("CLEAN_STEPS",  32'(n_dut_steps), 32'd36);
    check_val("CLEAN_MCT",    32'(bus.MCT_CNT), 32'd2);
    check_val("CLEAN_TCODE",  32'(bus.TCODE),   32'd12);
    check_val("CLEAN_SEQERR", 32'(bus.SEQERR),  32'd0);
    check_val("CLEAN_MULTI",  32'(bus.MULTI),   32'd0);

    // Two-cycle overlap at every transition
    for (int k = 1; k <= 12; k++) begin
      repeat (2) step(onehot(last_code) | onehot(k), 1'b0, 1'b0);
      step(onehot(k), 1'b0, 1'b0);
      lag = 0;
      while (!bus.TSTEP && lag < 10) begin
        step(onehot(k), 1'b0, 1'b0);
        lag++;
      end
      check_val("OVL_LAG", 32'(lag), 32'd3);
      drive_code(k, 47 - 1 - lag);
    end
    check_val("OVL_MULTI", 32'(bus.MULTI),   32'd0);
    check_val("OVL_MCT",   32'(bus.MCT_CNT), 32'd3);

    // Sequence error T05 -> T07
    for (int k = 1; k <= 5; k++) drive_code(k, 20);
    drive_code(7, 20);
    check_val("SEQ_FLAG",    32'(bus.SEQERR),  32'd1);
    check_val("SEQ_ERRCODE", 32'(bus.ERRCODE), 32'h67);
    check_val("SEQ_TCODE",   32'(bus.TCODE),   32'd7);
    drive_code(5, 20);
    drive_code(9, 20);
    check_val("SEQ_ERRCODE_KEEP", 32'(bus.ERRCODE), 32'h67);
    step(onehot(9), 1'b0, 1'b1);
    step(onehot(9), 1'b0, 1'b0);
    check_val("CLR_ERRCODE", 32'(bus.ERRCODE), 32'h00);
    check_val("CLR_SEQERR",  32'(bus.SEQERR),  32'd0);

    // Multi-hot MT02+MT09
    steps_before = n_dut_steps;
    drive_pat(onehot(2) | onehot(9), 10);
    check_val("MULTI_FLAG",  32'(bus.MULTI),     32'd1);
    check_val("MULTI_TCODE", 32'(bus.TCODE),     32'd9);
    check_val("MULTI_NOSTEP", 32'(n_dut_steps),  32'(steps_before));
    drive_code(10, 20);
    step(onehot(10), 1'b0, 1'b1);

    // Stall on held T08, then T03
    drive_code(11, 20);
    drive_code(12, 20);
    for (int k = 1; k <= 7; k++) drive_code(k, 20);
    cnt = 0;
    step(onehot(8), 1'b0, 1'b0);
    while (!bus.TSTEP && cnt < 10) begin step(onehot(8), 1'b0, 1'b0); cnt++; end
    lag = 0;
    while (!bus.STALL && lag < 300) begin step(onehot(8), 1'b0, 1'b0); lag++; end
    check_val("STALL_DELAY", 32'(lag), 32'd128);
    drive_code(8, 200 - 1 - cnt - lag);
    drive_code(3, 20);
    check_val("STALL_T3_TCODE",  32'(bus.TCODE),  32'd3);
    check_val("STALL_T3_SEQERR", 32'(bus.SEQERR), 32'd0);
    check_val("STALL_T3_STALL",  32'(bus.STALL),  32'd0);

    // GOJAM mid-T06, then T01
    drive_code(4, 20);
    drive_code(5, 20);
    drive_code(6, 15);
    saved_mct = int'(bus.MCT_CNT);
    step(onehot(6), 1'b1, 1'b0);
    check_val("GOJAM_TCODE",  32'(bus.TCODE),  32'd0);
    check_val("GOJAM_TVALID", 32'(bus.TVALID), 32'd0);
    drive_code(6, 10);
    drive_code(1, 20);
    check_val("GOJAM_T1_TCODE",  32'(bus.TCODE),   32'd1);
    check_val("GOJAM_T1_SEQERR", 32'(bus.SEQERR),  32'd0);
    check_val("GOJAM_MCT",       32'(bus.MCT_CNT), 32'(saved_mct));

    // Randomized pulse trains
    rnd_mode = 1;
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 99);
      c = (m_tcode % 12) + 1;
      if (kind < 60) begin
        ov = $urandom_range(0, 2);
        for (int i = 0; i < ov; i++) step(onehot(last_code) | onehot(c), 1'b0, 1'b0);
        drive_code(c, $urandom_range(5, 60));
      end else if (kind < 70) begin
        drive_code($urandom_range(1, 12), $urandom_range(4, 40));
      end else if (kind < 78) begin
        a = $urandom_range(1, 12);
        b = (a % 12) + $urandom_range(1, 10);
        if (b > 12) b = b - 12;
        drive_pat(onehot(a) | onehot(b), $urandom_range(1, 12));
      end else if (kind < 84) begin
        drive_pat(12'd0, $urandom_range(1, 5));
      end else if (kind < 90) begin
        drive_pat(onehot($urandom_range(1, 12)), $urandom_range(1, SETTLE - 1));
      end else if (kind < 94) begin
        drive_code(c, $urandom_range(130, 180));
      end else begin
        step(onehot(last_code), 1'b1, 1'b0);
        drive_code(last_code, $urandom_range(2, 10));
      end
    end
    rnd_mode = 0;

    // Asynchronous reset mid-T04
    drive_code(4, 10);
    #4;
    RESET = 1'b1;
    model_reset();
    #1;
    check_val("ARST_TCODE",   32'(bus.TCODE),   32'd0);
    check_val("ARST_TVALID",  32'(bus.TVALID),  32'd0);
    check_val("ARST_MCT",     32'(bus.MCT_CNT), 32'd0);
    check_val("ARST_SEQERR",  32'(bus.SEQERR),  32'd0);
    check_val("ARST_MULTI",   32'(bus.MULTI),   32'd0);
    check_val("ARST_ERRCODE", 32'(bus.ERRCODE), 32'd0);
    check_val("ARST_STALL",   32'(bus.STALL),   32'd0);
    repeat (2) @(posedge SIM_CLK);
    @(negedge SIM_CLK);
    RESET = 1'b0;
    model_reset();
    drive_code(1, 20);
    drive_code(2, 20);
    check_val("POSTRST_TCODE", 32'(bus.TCODE),   32'd2);
    check_val("POSTRST_MCT",   32'(bus.MCT_CNT), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
